// File: rtl/line_xfer_engine_pkg.sv
// Shared types for the line transfer engine: request opcodes, FSM states and
// the line-base address helper.
package line_xfer_engine_pkg;

    typedef enum logic [1:0] {
        XFER_NOP   = 2'd0,
        XFER_READ  = 2'd1,
        XFER_WRITE = 2'd2
    } xfer_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_XFER,
        WR_XFER,
        DONE
    } xfer_state_t;

    // Clears the in-line offset bits; callers truncate to their address width.
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int offbits);
        return addr & ~((64'd1 << offbits) - 64'd1);
    endfunction

endpackage

// File: rtl/line_xfer_engine_if.sv
// Cache-side request/data channel and word-beat memory port of the engine.
interface xfer_req_if #(
    parameter int ADDRBITS  = 32,
    parameter int DATABITS  = 32,
    parameter int LINEITEMS = 16
);
    localparam int IW = $clog2(LINEITEMS);

    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [ADDRBITS-1:0] req_addr;
    logic [DATABITS-1:0] wr_word;
    logic [IW-1:0]       wr_idx;
    logic [DATABITS-1:0] rd_word;
    logic                rd_valid;
    logic [IW-1:0]       rd_idx;
    logic                done;

    modport master (
        output req_valid, req_op, req_addr, wr_word,
        input  req_ready, wr_idx, rd_word, rd_valid, rd_idx, done
    );
    modport slave (
        input  req_valid, req_op, req_addr, wr_word,
        output req_ready, wr_idx, rd_word, rd_valid, rd_idx, done
    );
endinterface

interface xfer_mem_if #(
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32
);
    logic                mem_cmd_valid;
    logic                mem_cmd_ready;
    logic                mem_cmd_write;
    logic [ADDRBITS-1:0] mem_addr;
    logic [DATABITS-1:0] mem_wdata;
    logic [DATABITS-1:0] mem_rdata;
    logic                mem_rvalid;

    modport master (
        output mem_cmd_valid, mem_cmd_write, mem_addr, mem_wdata,
        input  mem_cmd_ready, mem_rdata, mem_rvalid
    );
    modport slave (
        input  mem_cmd_valid, mem_cmd_write, mem_addr, mem_wdata,
        output mem_cmd_ready, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/line_xfer_engine_beat_counter.sv
// Issue/return beat counters shared by fill and writeback; write transfers
// never pulse ret, so outstanding simply tracks issue_cnt there.
module xfer_beat_counter #(
    parameter int LINEITEMS = 16,
    parameter int MAXOUT    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       issue,
    input  logic                       ret,
    output logic [$clog2(LINEITEMS):0] issue_cnt,
    output logic [$clog2(LINEITEMS):0] ret_cnt,
    output logic [$clog2(LINEITEMS):0] outstanding,
    output logic                       issue_left,
    output logic                       out_room
);
    localparam int CW = $clog2(LINEITEMS) + 1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (clr) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            if (issue) issue_cnt <= issue_cnt + CW'(1);
            if (ret)   ret_cnt   <= ret_cnt + CW'(1);
        end
    end

    assign outstanding = issue_cnt - ret_cnt;
    assign issue_left  = issue_cnt < CW'(LINEITEMS);
    assign out_room    = outstanding < CW'(MAXOUT);

endmodule

// File: rtl/line_xfer_engine.sv
// Splits one line fill or writeback into per-word memory beats; read commands
// are pipelined up to MAXOUT deep, one line transfer in flight at a time.
module line_xfer_engine
    import line_xfer_engine_pkg::*;
#(
    parameter int ADDRBITS  = 32,
    parameter int DATABITS  = 32,
    parameter int LINEITEMS = 16,
    parameter int MAXOUT    = 4
) (
    input  logic        clock,
    input  logic        reset,
    xfer_req_if.slave   req,
    xfer_mem_if.master  mem,
    output logic [31:0] lines_read,
    output logic [31:0] lines_written
);
    localparam int IW   = $clog2(LINEITEMS);
    localparam int CW   = IW + 1;
    localparam int OFFB = $clog2(LINEITEMS * DATABITS / 8);
    localparam int BSH  = $clog2(DATABITS / 8);

    xfer_state_t         state;
    logic                fill;
    logic [ADDRBITS-1:0] base;
    logic [CW-1:0]       issue_cnt, ret_cnt, outstanding;
    logic                issue_left, out_room;
    logic                issue_fire, ret_fire;

    xfer_beat_counter #(.LINEITEMS(LINEITEMS), .MAXOUT(MAXOUT)) u_cnt (
        .clock       (clock),
        .reset       (reset),
        .clr         (state == IDLE),
        .issue       (issue_fire),
        .ret         (ret_fire),
        .issue_cnt   (issue_cnt),
        .ret_cnt     (ret_cnt),
        .outstanding (outstanding),
        .issue_left  (issue_left),
        .out_room    (out_room)
    );

    // Command controls decode only registered state, so a pending beat holds
    // address and data steady until the memory takes it.
    assign mem.mem_cmd_valid = (state == RD_XFER && issue_left && out_room) ||
                               (state == WR_XFER && issue_left);
    assign mem.mem_cmd_write = (state == WR_XFER);
    assign mem.mem_addr      = (state == RD_XFER || state == WR_XFER) ?
                               base + (ADDRBITS'(issue_cnt[IW-1:0]) << BSH) : '0;
    assign mem.mem_wdata     = (state == WR_XFER) ? req.wr_word : '0;
    assign req.wr_idx        = issue_cnt[IW-1:0];

    assign issue_fire = mem.mem_cmd_valid && mem.mem_cmd_ready;
    assign ret_fire   = (state == RD_XFER) && mem.mem_rvalid && (outstanding != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            fill          <= 1'b0;
            base          <= '0;
            req.req_ready <= 1'b1;
            req.done      <= 1'b0;
            req.rd_valid  <= 1'b0;
            req.rd_word   <= '0;
            req.rd_idx    <= '0;
            lines_read    <= '0;
            lines_written <= '0;
        end else begin
            req.done     <= 1'b0;
            req.rd_valid <= ret_fire;
            if (ret_fire) begin
                req.rd_word <= mem.mem_rdata;
                req.rd_idx  <= ret_cnt[IW-1:0];
            end
            unique case (state)
                IDLE: begin
                    if (req.req_valid && (req.req_op == XFER_READ || req.req_op == XFER_WRITE)) begin
                        state         <= (req.req_op == XFER_READ) ? RD_XFER : WR_XFER;
                        fill          <= (req.req_op == XFER_READ);
                        base          <= ADDRBITS'(line_base(64'(req.req_addr), OFFB));
                        req.req_ready <= 1'b0;
                    end
                end
                RD_XFER: begin
                    if (ret_cnt == CW'(LINEITEMS)) begin
                        state    <= DONE;
                        req.done <= 1'b1;
                    end
                end
                WR_XFER: begin
                    if (issue_cnt == CW'(LINEITEMS)) begin
                        state    <= DONE;
                        req.done <= 1'b1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    req.req_ready <= 1'b1;
                    if (fill) begin
                        if (lines_read != '1) lines_read <= lines_read + 32'd1;
                    end else begin
                        if (lines_written != '1) lines_written <= lines_written + 32'd1;
                    end
                end
            endcase
        end
    end

    // A read return with nothing outstanding breaks the memory protocol.
    rvalid_has_cmd: assert property (@(posedge clock) disable iff (reset)
        (state == RD_XFER && mem.mem_rvalid) |-> (outstanding != '0));

endmodule

// File: tb/tb_line_xfer_engine.sv
// Directed bench for line_xfer_engine: memory responder with configurable
// ready pattern and read latency, cache word source, directed checks.
module tb_line_xfer_engine;
    import line_xfer_engine_pkg::*;

    localparam int AB = 32;
    localparam int DB = 32;
    localparam int LI = 16;
    localparam int MO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] lines_read, lines_written;

    xfer_req_if #(.ADDRBITS(AB), .DATABITS(DB), .LINEITEMS(LI)) rq();
    xfer_mem_if #(.ADDRBITS(AB), .DATABITS(DB)) mm();

    line_xfer_engine #(.ADDRBITS(AB), .DATABITS(DB), .LINEITEMS(LI), .MAXOUT(MO)) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (rq),
        .mem           (mm),
        .lines_read    (lines_read),
        .lines_written (lines_written)
    );

    always #5 clock = ~clock;

    assign rq.wr_word = 32'h0000_00A0 + 32'(rq.wr_idx);

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, lat = 1, rdy_mode = 0;
    bit stray = 1'b0, ret_now;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] c_addr[$], c_data[$];
    bit          c_wr[$];
    logic [31:0] r_word[$];
    int          r_idx[$];
    int done_cnt = 0, done_cyc = 0, acc_cyc = 0;
    int out_now = 0, out_max = 0, stall_err = 0, errs, base_done;
    bit prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_data;

    // Memory model and monitor; everything is evaluated mid-cycle.
    always @(negedge clock) begin
        cyc++;
        ret_now = 1'b0;
        if (stray) begin
            mm.mem_rvalid = 1'b1;
            mm.mem_rdata  = 32'hDEAD_BEEF;
            stray = 1'b0;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mm.mem_rvalid = 1'b1;
            mm.mem_rdata  = pend_addr.pop_front();
            void'(pend_due.pop_front());
            ret_now = 1'b1;
        end else begin
            mm.mem_rvalid = 1'b0;
            mm.mem_rdata  = '0;
        end
        mm.mem_cmd_ready = (rdy_mode == 0) || cyc[0];
        if (prev_stall && (!mm.mem_cmd_valid || mm.mem_addr !== prev_addr || mm.mem_wdata !== prev_data))
            stall_err++;
        prev_stall = mm.mem_cmd_valid && !mm.mem_cmd_ready;
        prev_addr  = mm.mem_addr;
        prev_data  = mm.mem_wdata;
        if (mm.mem_cmd_valid && mm.mem_cmd_ready) begin
            c_addr.push_back(mm.mem_addr);
            c_data.push_back(mm.mem_wdata);
            c_wr.push_back(mm.mem_cmd_write);
            if (!mm.mem_cmd_write) begin
                pend_addr.push_back(mm.mem_addr);
                pend_due.push_back(cyc + lat);
                out_now++;
            end
        end
        if (out_now > out_max) out_max = out_now;
        if (ret_now) out_now--;
        if (rq.rd_valid) begin
            r_word.push_back(rq.rd_word);
            r_idx.push_back(int'(rq.rd_idx));
        end
        if (rq.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rq.req_valid && rq.req_ready) acc_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr);
        rq.req_op    = op;
        rq.req_addr  = addr;
        rq.req_valid = 1'b1;
        tick(1);
        rq.req_valid = 1'b0;
    endtask

    task automatic clear_logs();
        c_addr.delete(); c_data.delete(); c_wr.delete();
        r_word.delete(); r_idx.delete();
        out_now = 0; out_max = 0; stall_err = 0;
    endtask

    task automatic wait_done(input string tag, input int base);
        int t = 0;
        while (done_cnt == base && t < 400) begin
            tick(1);
            t++;
        end
        chk(tag, 32'(done_cnt > base), 32'd1);
    endtask

    task automatic chk_fill(input string tag, input logic [31:0] base_addr);
        errs = 0;
        for (int i = 0; i < r_word.size(); i++)
            if (r_word[i] !== base_addr + 32'(4 * i) || r_idx[i] != i) errs++;
        chk({tag, "_nrd"}, 32'(r_word.size()), 32'd16);
        chk({tag, "_words"}, 32'(errs), 32'd0);
    endtask

    initial begin
        rq.req_valid = 1'b0;
        rq.req_op    = 2'd0;
        rq.req_addr  = '0;
        reset = 1'b1;
        tick(3);
        chk("rst_req_ready", 32'(rq.req_ready), 32'd1);
        chk("rst_done", 32'(rq.done), 32'd0);
        chk("rst_rd_valid", 32'(rq.rd_valid), 32'd0);
        chk("rst_cmd_valid", 32'(mm.mem_cmd_valid), 32'd0);
        chk("rst_lines_read", lines_read, 32'd0);
        chk("rst_lines_written", lines_written, 32'd0);
        reset = 1'b0;
        tick(2);

        // Fill with 1-cycle read latency, minimum-latency path
        clear_logs(); lat = 1; rdy_mode = 0; base_done = done_cnt;
        send(XFER_READ, 32'h0000_1234);
        wait_done("fill1_timeout", base_done);
        tick(3);
        errs = 0;
        for (int i = 0; i < c_addr.size(); i++)
            if (c_addr[i] !== 32'h1200 + 32'(4 * i) || c_wr[i]) errs++;
        chk("fill1_ncmd", 32'(c_addr.size()), 32'd16);
        chk("fill1_addr", 32'(errs), 32'd0);
        chk_fill("fill1", 32'h1200);
        chk("fill1_done_once", 32'(done_cnt - base_done), 32'd1);
        chk("fill1_latency", 32'(done_cyc - acc_cyc - 1), 32'(LI + 2));
        chk("fill1_lines_read", lines_read, 32'd1);

        // Writeback with memory ready every other cycle
        clear_logs(); rdy_mode = 1; base_done = done_cnt;
        send(XFER_WRITE, 32'h8000_0040);
        wait_done("wb1_timeout", base_done);
        tick(3);
        errs = 0;
        for (int i = 0; i < c_addr.size(); i++)
            if (c_addr[i] !== 32'h8000_0040 + 32'(4 * i) || c_data[i] !== 32'hA0 + 32'(i) || !c_wr[i]) errs++;
        chk("wb1_ncmd", 32'(c_addr.size()), 32'd16);
        chk("wb1_beats", 32'(errs), 32'd0);
        chk("wb1_stable", 32'(stall_err), 32'd0);
        chk("wb1_done_once", 32'(done_cnt - base_done), 32'd1);
        chk("wb1_lines_written", lines_written, 32'd1);

        // Writeback with memory always ready
        clear_logs(); rdy_mode = 0; base_done = done_cnt;
        send(XFER_WRITE, 32'h0000_0100);
        wait_done("wb2_timeout", base_done);
        tick(3);
        chk("wb2_latency", 32'(done_cyc - acc_cyc - 1), 32'(LI + 1));
        chk("wb2_lines_written", lines_written, 32'd2);

        // Long read latency exercises the outstanding limit
        clear_logs(); lat = 10; base_done = done_cnt;
        send(XFER_READ, 32'h0000_2000);
        wait_done("fill2_timeout", base_done);
        tick(3);
        chk("fill2_max_outstanding", 32'(out_max), 32'(MO));
        chk_fill("fill2", 32'h2000);
        chk("fill2_done_once", 32'(done_cnt - base_done), 32'd1);

        // NOP and op 3 are dropped
        clear_logs(); lat = 1; base_done = done_cnt;
        rq.req_op = 2'd0; rq.req_addr = 32'h3000; rq.req_valid = 1'b1;
        tick(3);
        chk("nop_req_ready", 32'(rq.req_ready), 32'd1);
        rq.req_op = 2'd3;
        tick(3);
        chk("op3_req_ready", 32'(rq.req_ready), 32'd1);
        rq.req_valid = 1'b0;
        tick(3);
        chk("nop_no_cmds", 32'(c_addr.size()), 32'd0);
        chk("nop_no_done", 32'(done_cnt - base_done), 32'd0);
        chk("nop_lines_read", lines_read, 32'd2);
        chk("nop_lines_written", lines_written, 32'd2);

        // Reset in the middle of a fill, then a stray return
        clear_logs(); lat = 3;
        send(XFER_READ, 32'h0000_0100);
        for (int t = 0; t < 200 && r_word.size() < 5; t++) tick(1);
        chk("mid_rd_progress", 32'(r_word.size() >= 5), 32'd1);
        reset = 1'b1;
        pend_addr.delete(); pend_due.delete();
        #1;
        chk("mid_rst_req_ready", 32'(rq.req_ready), 32'd1);
        chk("mid_rst_rd_valid", 32'(rq.rd_valid), 32'd0);
        chk("mid_rst_cmd_valid", 32'(mm.mem_cmd_valid), 32'd0);
        chk("mid_rst_lines_read", lines_read, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        clear_logs(); base_done = done_cnt;
        stray = 1'b1;
        tick(3);
        chk("stray_ignored", 32'(r_word.size()), 32'd0);
        chk("stray_no_done", 32'(done_cnt - base_done), 32'd0);
        lat = 1;
        send(XFER_READ, 32'h0000_0040);
        wait_done("fill3_timeout", base_done);
        tick(3);
        chk_fill("fill3", 32'h0000_0040);
        chk("fill3_lines_read", lines_read, 32'd1);

        // Saturating fill counter
        force dut.lines_read = 32'hFFFF_FFFF;
        tick(1);
        release dut.lines_read;
        clear_logs(); base_done = done_cnt;
        send(XFER_READ, 32'h0000_0500);
        wait_done("fill4_timeout", base_done);
        tick(3);
        chk("fill4_lines_read_sat", lines_read, 32'hFFFF_FFFF);
        chk("fill4_done_once", 32'(done_cnt - base_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_xfer_engine.md
Name: line_xfer_engine

Overview:
Miss/eviction transfer engine directly downstream of the cache's next-level master port. It accepts one line-granular request from the cache: a line fill or a dirty-line writeback. It splits the request into per-word beats on a simple command/response memory port and streams the words back to the cache, or pulls them from it. One request is in flight at a time. Read beats are pipelined: commands are issued without waiting for earlier data.

Parameters:
ADDRBITS, 32, byte address width
DATABITS, 32, word width
LINEITEMS, 16, words per line (power of 2, >=2)
MAXOUT, 4, max outstanding read beats on memory port (1..LINEITEMS)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  cache request present
req_ready  out  1  engine idle, accepts request
req_op  in  2  xfer_op_t: XFER_NOP=0, XFER_READ=1, XFER_WRITE=2
req_addr  in  ADDRBITS  line address; offset bits ignored
wr_word  in  DATABITS  writeback word at index wr_idx (combinational from cache)
wr_idx  out  $clog2(LINEITEMS)  word index requested from cache
rd_word  out  DATABITS  fill word
rd_valid  out  1  rd_word/rd_idx valid this cycle
rd_idx  out  $clog2(LINEITEMS)  fill word index
done  out  1  one-cycle pulse, transfer complete
mem_cmd_valid  out  1  memory beat command
mem_cmd_ready  in  1  memory accepts command
mem_cmd_write  out  1  1=write beat, 0=read beat
mem_addr  out  ADDRBITS  word-aligned byte address of beat
mem_wdata  out  DATABITS  write beat data
mem_rdata  in  DATABITS  read return data (in order)
mem_rvalid  in  1  read return valid
lines_read  out  32  completed fills, saturating
lines_written  out  32  completed writebacks, saturating

Behaviour:
- States: IDLE, RD_XFER, WR_XFER, DONE.
- Reset (async): state=IDLE. All outputs 0 except req_ready=1. Counters cleared. A transfer in progress is abandoned. Late mem_rvalid beats after reset are ignored until the next READ is accepted.
- IDLE: req_ready=1. A request is accepted on req_valid&req_ready.
  - XFER_READ -> RD_XFER; XFER_WRITE -> WR_XFER.
  - XFER_NOP or 3: ignored, stay IDLE, no done.
  - base = req_addr with low $clog2(LINEITEMS*DATABITS/8) bits zeroed, latched.
- Beat address = base + issue_cnt*(DATABITS/8). Beats issued in index order 0..LINEITEMS-1, no wrap-around within the line.
- RD_XFER:
  - mem_cmd_valid=1 while issue_cnt<LINEITEMS and outstanding<MAXOUT. A beat issues when mem_cmd_ready is high in the same cycle; issue_cnt increments.
  - outstanding = issue_cnt - ret_cnt. Issue and return in the same cycle leave it unchanged.
  - Each mem_rvalid: rd_word=mem_rdata, rd_idx=ret_cnt, rd_valid=1 registered, 1-cycle latency. ret_cnt increments.
  - mem_rvalid while outstanding==0 is a protocol error: ignored, assertion fires.
  - ret_cnt==LINEITEMS -> DONE.
- WR_XFER:
  - wr_idx=issue_cnt; mem_wdata=wr_word; mem_cmd_write=1; mem_cmd_valid=1.
  - Each accepted beat increments issue_cnt. At LINEITEMS -> DONE. No responses are expected.
- mem_cmd_valid, once high, holds and keeps address/data stable until mem_cmd_ready.
- DONE: done=1 for one cycle. lines_read or lines_written increments (saturating at 2^32-1). req_ready=0 this cycle. -> IDLE.
- Minimum transfer latency, acceptance to done, with mem_cmd_ready=1 and rvalid 1 cycle after command: LINEITEMS+2 cycles for read, LINEITEMS+1 for write.

Decomposition:
- cachepkg additions: xfer_op_t enum, xfer_state_t enum, and a function line_base(addr).
- One sub-module: xfer_beat_counter, holding the issue/return counters, outstanding count, and MAXOUT compare. It is reused for both directions.

Test Plan:
- Fill, LINEITEMS=16, mem ready always, rdata=addr, rvalid 1 cycle later; req_addr=0x0000_1234 -> mem_addr 0x1200..0x123C in order; rd_idx 0..15 with rd_word=0x1200+4*idx; done at cycle 18; lines_read=1.
- Writeback to 0x8000_0040, cache returns wr_word=0xA0+wr_idx, mem_cmd_ready toggling every other cycle -> 16 write beats at 0x8000_0040..0x8000_007C, data 0xA0..0xAF, held stable while stalled; done once; lines_written=1.
- Fill with rvalid latency 10, MAXOUT=4 -> never more than 4 commands outstanding; all 16 words in order; done exactly once.
- req_op=XFER_NOP and 3 with req_valid=1 -> no memory commands, no done, req_ready stays 1, counters unchanged.
- Reset asserted after 5 read beats returned, then a stray rvalid -> outputs at reset values; stray beat ignored; a new READ of 0x40 completes normally with rd_idx starting at 0.
- lines_read preloaded via force to 0xFFFF_FFFF, one fill -> lines_read stays 0xFFFF_FFFF.
